prim_skid_buf: RTL
==================

PRIM_SKID_BUF -- requirements
Module: prim_skid_buf

Interface
- REQ-001: Width, default 1, data bits carried per beat.
- REQ-002: clk_i  input  1  single clock; all state on rising edge.
- REQ-003: rst_i  input  1  reset, asynchronous, active-high.
- REQ-004: flush_i  input  1  synchronous clear of all stored beats.
- REQ-005: valid_i  input  1  upstream beat present.
- REQ-006: ready_o  output  1  buffer accepts a beat this cycle.
- REQ-007: data_i  input  Width  upstream data.
- REQ-008: valid_o  output  1  downstream beat present.
- REQ-009: ready_i  input  1  downstream accepts a beat this cycle.
- REQ-010: data_o  output  Width  downstream data.
- REQ-011: err_o  output  1  integrity error on the presented beat.

Function
- REQ-012: Two storage slots, main and skid; states EMPTY, ONE (main full), TWO (main and skid full).
- REQ-013: push = valid_i & ready_o; pop = valid_o & ready_i; a beat transfers only on a handshake.
- REQ-014: ready_o and valid_o are driven directly from state flops only: ready_o = (state != TWO), valid_o = (state != EMPTY); no combinational path from any input to any output.
- REQ-015: data_o always equals the main slot; latency from accepted data_i to data_o is exactly 1 cycle when EMPTY.
- REQ-016: EMPTY: push -> main <= data_i, go ONE.
- REQ-017: ONE: push & pop -> main <= data_i, stay ONE; push only -> skid <= data_i, go TWO; pop only -> go EMPTY.
- REQ-018: TWO: pop -> main <= skid, go ONE; no push possible (ready_o low).
- REQ-019: Beat order is strictly preserved; no beat is dropped or duplicated.
- REQ-020: valid_o, once high, stays high with data_o stable until pop.
- REQ-021: flush_i has priority over push and pop in the same cycle: state -> EMPTY next cycle; the beat offered that cycle is discarded.
- REQ-022: Sustained push & pop in ONE gives one beat per cycle throughput.
- REQ-023: Illegal state encodings recover to EMPTY.

Reset
- REQ-024: rst_i asserted at any time (including mid-handshake) forces state EMPTY immediately; valid_o=0, ready_o=1, data_o=0, err_o=0 while asserted and after release.
- REQ-025: Data slots reset to all-zeros.

Configuration
- REQ-026: Macro PRIM_SKID_BUF_INTG_EN defined: one even-parity bit computed over data_i on push, stored with each slot, moved with the data; err_o = valid_o & (parity(data_o) != stored bit).
- REQ-027: Macro undefined: no parity storage; err_o tied to 0; port list unchanged.

Structure
- REQ-028: Package prim_skid_buf_pkg holds the state enum typedef (EMPTY, ONE, TWO) and its encoding width constant.
- REQ-029: One sub-module, prim_skid_buf_slot: Width-wide (plus optional parity) register with load enable and asynchronous active-high reset, instantiated for main and skid.

Verification (Width=8)
- REQ-030: Reset release, valid_i=1, data_i=0x5A, ready_i=1 -> next cycle valid_o=1, data_o=0x5A; stream 0x01..0x10 back-to-back -> 16 beats out in order, one per cycle.
- REQ-031: ready_i=0, push 0xA1 then 0xA2 -> ready_o=0 after second push, data_o=0xA1; ready_i=1 for 2 cycles -> 0xA1 then 0xA2, ready_o=1 again.
- REQ-032: State TWO (0x11,0x22) with flush_i=1 and ready_i=1 same cycle -> next cycle valid_o=0, ready_o=1, no beat observed popped.
- REQ-033: rst_i pulsed while in ONE holding 0x77 -> valid_o=0, data_o=0x00 during and after reset.
- REQ-034: PRIM_SKID_BUF_INTG_EN defined, force stored parity flip on main holding 0x3C -> err_o=1 while valid_o=1; undefined build -> err_o=0 under same stimulus.
- REQ-035: Random valid_i/ready_i at 50% for 10000 cycles -> scoreboard shows in-order, lossless delivery; valid_o never drops without pop.

Source files
------------

// File: rtl/prim_skid_buf_pkg.sv
// prim_skid_buf_pkg: state encoding for the skid buffer FSM and the optional integrity width.
// Defining PRIM_SKID_BUF_INTG_EN adds one even-parity bit to every stored slot.
package prim_skid_buf_pkg;
    localparam int StateW = 2;
    typedef enum logic [StateW-1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
`ifdef PRIM_SKID_BUF_INTG_EN
    localparam int IntgW = 1;
`else
    localparam int IntgW = 0;
`endif
endpackage

// File: rtl/prim_skid_buf_if.sv
// prim_skid_buf_if: upstream/downstream handshake bundle for prim_skid_buf.
interface prim_skid_buf_if #(parameter int Width = 1);
    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    logic [Width-1:0] data_i;
    logic             valid_o;
    logic             ready_i;
    logic [Width-1:0] data_o;
    logic             err_o;
    modport slave (input flush_i, valid_i, data_i, ready_i, output ready_o, valid_o, data_o, err_o);
    modport master (output flush_i, valid_i, data_i, ready_i, input ready_o, valid_o, data_o, err_o);
endinterface

// File: rtl/prim_skid_buf_slot.sv
// prim_skid_buf_slot: one storage slot (data plus optional parity) with load enable.
module prim_skid_buf_slot #(parameter int Width = 1) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_load,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);
    logic [Width-1:0] r_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_q <= '0;
        else if (i_load) r_q <= i_d;
    end
    assign o_q = r_q;
endmodule

// File: rtl/prim_skid_buf.sv
// prim_skid_buf: two-slot skid buffer with fully registered valid/ready outputs.
// Define PRIM_SKID_BUF_INTG_EN to carry an even-parity bit with each beat and flag it on err_o.
module prim_skid_buf
    import prim_skid_buf_pkg::*;
#(parameter int Width = 1) (
    input  logic              clk_i,
    input  logic              rst_i,
    prim_skid_buf_if.slave    bus
);
    localparam int SW = Width + IntgW;
    state_e        r_state, w_next;
    logic          w_push, w_pop, w_ld_main, w_ld_skid;
    logic [SW-1:0] w_in, w_main_d, w_main_q, w_skid_q;
    assign bus.ready_o = (r_state != TWO);
    assign bus.valid_o = (r_state != EMPTY);
    assign w_push = bus.valid_i & bus.ready_o;
    assign w_pop = bus.valid_o & bus.ready_i;
`ifdef PRIM_SKID_BUF_INTG_EN
    assign w_in = {^bus.data_i, bus.data_i};
    assign bus.err_o = bus.valid_o & ((^w_main_q[Width-1:0]) != w_main_q[Width]);
`else
    assign w_in = bus.data_i;
    assign bus.err_o = 1'b0;
`endif
    assign bus.data_o = w_main_q[Width-1:0];
    // flush wins over any handshake; unknown encodings fall back to EMPTY
    always_comb begin
        w_next = EMPTY;
        w_ld_main = 1'b0;
        w_ld_skid = 1'b0;
        if (!bus.flush_i) begin
            case (r_state)
                EMPTY: begin
                    w_next = w_push ? ONE : EMPTY;
                    w_ld_main = w_push;
                end
                ONE: begin
                    w_next = (w_push && !w_pop) ? TWO : (w_pop && !w_push) ? EMPTY : ONE;
                    w_ld_main = w_push & w_pop;
                    w_ld_skid = w_push & ~w_pop;
                end
                TWO: begin
                    w_next = w_pop ? ONE : TWO;
                    w_ld_main = w_pop;
                end
                default: w_next = EMPTY;
            endcase
        end
    end
    assign w_main_d = (r_state == TWO) ? w_skid_q : w_in;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= EMPTY;
        else r_state <= w_next;
    end
    prim_skid_buf_slot #(.Width(SW)) u_main (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_load(w_ld_main),
        .i_d   (w_main_d),
        .o_q   (w_main_q)
    );
    prim_skid_buf_slot #(.Width(SW)) u_skid (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_load(w_ld_skid),
        .i_d   (w_in),
        .o_q   (w_skid_q)
    );
endmodule
